// File: rtl/game_pkg.sv
// Shared types and helpers for the symbol-counting game sequencer.
// Holds the period encoding, countdown width and an absolute-difference helper.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRELIM = 3'd1,
        GAME   = 3'd2,
        ANSWER = 3'd3,
        POST   = 3'd4,
        WIN    = 3'd5,
        LOSE   = 3'd6
    } period_e;

    localparam int SECS_W = 4;

    // Unsigned |a - b|; never wraps because the larger operand is always the minuend.
    function automatic logic [31:0] abs_diff(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/player_counter.sv
// Saturating up/down counter for one player.
// Ports: Clk100M/Rst_n clock and async active-low reset; clr synchronous clear;
//   en count enable; up/down step pulses; count registered value;
//   count_nxt the value count takes on the next edge (used for same-edge judgement).
module player_counter #(
    parameter int CNT_W = 8
) (
    input  logic             Clk100M,
    input  logic             Rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_nxt;

    // up and down together cancel; both ends saturate.
    always_comb begin
        w_nxt = r_count;
        if (clr) begin
            w_nxt = '0;
        end else if (en && up && !down && (r_count != '1)) begin
            w_nxt = r_count + CNT_W'(1);
        end else if (en && down && !up && (r_count != '0)) begin
            w_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_nxt;
        end
    end

    assign count     = r_count;
    assign count_nxt = w_nxt;

endmodule

// File: rtl/game_sequencer.sv
// Period/level controller: prelim -> game -> answer -> post per level, judging players.
// Ports: Clk100M/Rst_n clock and async reset; tick1Hz second pulse; start (re)start;
//   genDone generator finished; numSpecial target count; up/down per-player pulses;
//   period/curLevel/secsLeft status; startGen generator kick; alive survivor mask;
//   userCount packed counts (player 0 in LSBs); levelComplete pulse; victory/lose flags.
module game_sequencer
    import game_pkg::*;
#(
    parameter int NUM_LEVELS  = 8,
    parameter int NUM_PLAYERS = 2,
    parameter int CNT_W       = 8,
    parameter int PRELIM_SECS = 3,
    parameter int ANSWER_SECS = 5,
    parameter int POST_SECS   = 3,
    parameter int TOL         = 0,
    localparam int LVL_W      = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic                         Clk100M,
    input  logic                         Rst_n,
    input  logic                         tick1Hz,
    input  logic                         start,
    input  logic                         genDone,
    input  logic [CNT_W-1:0]             numSpecial,
    input  logic [NUM_PLAYERS-1:0]       up,
    input  logic [NUM_PLAYERS-1:0]       down,
    output logic [2:0]                   period,
    output logic [LVL_W-1:0]             curLevel,
    output logic [3:0]                   secsLeft,
    output logic                         startGen,
    output logic [NUM_PLAYERS-1:0]       alive,
    output logic [NUM_PLAYERS*CNT_W-1:0] userCount,
    output logic                         levelComplete,
    output logic                         victory,
    output logic                         lose
);

    localparam logic [SECS_W-1:0] PRE_S = SECS_W'(PRELIM_SECS);
    localparam logic [SECS_W-1:0] ANS_S = SECS_W'(ANSWER_SECS);
    localparam logic [SECS_W-1:0] PST_S = SECS_W'(POST_SECS);
    localparam logic [LVL_W-1:0]  LAST  = LVL_W'(NUM_LEVELS - 1);

    period_e                r_period, w_period;
    logic [LVL_W-1:0]       r_level,  w_level;
    logic [SECS_W-1:0]      r_secs,   w_secs;
    logic                   r_sg,     w_sg;
    logic [NUM_PLAYERS-1:0] r_alive,  w_alive;
    logic                   r_lc,     w_lc;
    logic                   r_vic,    w_vic;
    logic                   r_lose,   w_lose;

    logic                   w_counting;
    logic                   w_last;
    logic [NUM_PLAYERS-1:0] w_en;
    logic [NUM_PLAYERS-1:0] w_pass;

    assign w_counting = (r_period == GAME) || (r_period == ANSWER);
    assign w_last     = tick1Hz && (r_secs == SECS_W'(1));

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        logic [CNT_W-1:0] w_cnt;
        logic [CNT_W-1:0] w_nxt;
        logic [CNT_W:0]   w_diff;

        assign w_en[gi] = w_counting && r_alive[gi];

        player_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .Clk100M  (Clk100M),
            .Rst_n    (Rst_n),
            .clr      (w_sg),
            .en       (w_en[gi]),
            .up       (up[gi]),
            .down     (down[gi]),
            .count    (w_cnt),
            .count_nxt(w_nxt)
        );

        // Judge on the post-update count so a pulse on the final tick edge counts.
        assign w_diff     = (CNT_W+1)'(abs_diff(32'(w_nxt), 32'(numSpecial)));
        assign w_pass[gi] = 32'(w_diff) <= 32'(TOL);

        assign userCount[gi*CNT_W +: CNT_W] = w_cnt;
    end

    always_comb begin
        w_period = r_period;
        w_level  = r_level;
        w_secs   = r_secs;
        w_sg     = 1'b0;
        w_alive  = r_alive;
        w_lc     = 1'b0;
        w_vic    = r_vic;
        w_lose   = r_lose;
        unique case (r_period)
            IDLE, WIN, LOSE: begin
                // start takes priority over a same-cycle tick
                if (start) begin
                    w_period = PRELIM;
                    w_level  = '0;
                    w_alive  = '1;
                    w_vic    = 1'b0;
                    w_lose   = 1'b0;
                    w_secs   = PRE_S;
                end
            end
            PRELIM: begin
                if (w_last) begin
                    w_period = GAME;
                    w_secs   = '0;
                    w_sg     = 1'b1;
                end else if (tick1Hz) begin
                    w_secs = r_secs - SECS_W'(1);
                end
            end
            GAME: begin
                if (genDone) begin
                    w_period = ANSWER;
                    w_secs   = ANS_S;
                end
            end
            ANSWER: begin
                if (w_last) begin
                    w_period = POST;
                    w_secs   = PST_S;
                    w_lc     = 1'b1;
                    w_alive  = r_alive & w_pass;
                end else if (tick1Hz) begin
                    w_secs = r_secs - SECS_W'(1);
                end
            end
            POST: begin
                if (w_last) begin
                    if (r_alive == '0) begin
                        w_period = LOSE;
                        w_secs   = '0;
                        w_lose   = 1'b1;
                    end else if (r_level == LAST) begin
                        w_period = WIN;
                        w_secs   = '0;
                        w_vic    = 1'b1;
                    end else begin
                        w_period = PRELIM;
                        w_level  = r_level + LVL_W'(1);
                        w_secs   = PRE_S;
                    end
                end else if (tick1Hz) begin
                    w_secs = r_secs - SECS_W'(1);
                end
            end
            default: begin
                w_period = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_period <= IDLE;
            r_level  <= '0;
            r_secs   <= '0;
            r_sg     <= 1'b0;
            r_alive  <= '1;
            r_lc     <= 1'b0;
            r_vic    <= 1'b0;
            r_lose   <= 1'b0;
        end else begin
            r_period <= w_period;
            r_level  <= w_level;
            r_secs   <= w_secs;
            r_sg     <= w_sg;
            r_alive  <= w_alive;
            r_lc     <= w_lc;
            r_vic    <= w_vic;
            r_lose   <= w_lose;
        end
    end

    assign period        = r_period;
    assign curLevel      = r_level;
    assign secsLeft      = r_secs;
    assign startGen      = r_sg;
    assign alive         = r_alive;
    assign levelComplete = r_lc;
    assign victory       = r_vic;
    assign lose          = r_lose;

endmodule
